// File: rtl/table_fsm_if.sv
// Bundle of the programming, stepping and observation signals between a
// sequence controller (master) and the table-driven state machine (slave).
interface table_fsm_if #(
  parameter int STATE_W = 3,
  parameter int IN_W    = 1,
  parameter int OUT_W   = 3,
  parameter int CNT_W   = 8
);
  logic                       step;
  logic [IN_W-1:0]            a;
  logic                       wr_en;
  logic [STATE_W+IN_W-1:0]    wr_addr;
  logic [STATE_W+OUT_W-1:0]   wr_data;
  logic                       clr_err;
  logic [STATE_W-1:0]         state;
  logic [OUT_W-1:0]           saida;
  logic                       err;
  logic [CNT_W-1:0]           step_cnt;

  modport master (
    output step, a, wr_en, wr_addr, wr_data, clr_err,
    input  state, saida, err, step_cnt
  );

  modport slave (
    input  step, a, wr_en, wr_addr, wr_data, clr_err,
    output state, saida, err, step_cnt
  );
endinterface

// File: rtl/table_fsm.sv
// Run-time programmable, table-driven registered-Mealy state machine.
// Each table entry, indexed by {state, a}, holds {next_state, out_code} and a
// valid bit. A step follows the addressed entry, or raises a sticky error when
// the entry is unprogrammed or points outside the legal state range.
module table_fsm #(
  parameter int STATE_W     = 3,
  parameter int IN_W        = 1,
  parameter int OUT_W       = 3,
  parameter int NUM_STATES  = 6,
  parameter int RESET_STATE = 0,
  parameter int RESET_OUT   = 0,
  parameter int CNT_W       = 8
) (
  input logic         clk,
  input logic         reset,
  table_fsm_if.slave  bus
);

  localparam int ADDR_W = STATE_W + IN_W;
  localparam int DATA_W = STATE_W + OUT_W;
  localparam int DEPTH  = 1 << ADDR_W;

  // One extra bit so NUM_STATES == 2^STATE_W is representable.
  localparam logic [STATE_W:0]   NUM_STATES_L = (STATE_W+1)'(NUM_STATES);
  localparam logic [STATE_W-1:0] RST_STATE_L  = STATE_W'(RESET_STATE);
  localparam logic [OUT_W-1:0]   RST_OUT_L    = OUT_W'(RESET_OUT);
  localparam logic [CNT_W-1:0]   CNT_MAX_L    = '1;

  // Table storage: payload is not reset, validity is.
  logic [DATA_W-1:0]  tbl_q [DEPTH];
  logic [DEPTH-1:0]   vld_q;
  logic [DEPTH-1:0]   vld_d;

  logic [STATE_W-1:0] state_q, state_d;
  logic [OUT_W-1:0]   saida_q, saida_d;
  logic               err_q,   err_d;
  logic [CNT_W-1:0]   cnt_q,   cnt_d;

  logic [ADDR_W-1:0]  lk_idx_s;
  logic [DATA_W-1:0]  lk_entry_s;
  logic [STATE_W-1:0] lk_next_s;
  logic [OUT_W-1:0]   lk_out_s;
  logic               lk_hit_s;
  logic [STATE_W-1:0] wr_state_s;
  logic               wr_ok_s;

  // Decode whether the incoming table write targets a legal state row.
  always_comb begin
    wr_state_s = bus.wr_addr[ADDR_W-1:IN_W];
    if (bus.wr_en && ({1'b0, wr_state_s} < NUM_STATES_L)) begin
      wr_ok_s = 1'b1;
    end else begin
      wr_ok_s = 1'b0;
    end
  end

  // Combinational read of the entry selected by the current state and input;
  // this sees pre-write contents when a write hits the same index.
  always_comb begin
    lk_idx_s   = {state_q, bus.a};
    lk_entry_s = tbl_q[lk_idx_s];
    lk_next_s  = lk_entry_s[DATA_W-1:OUT_W];
    lk_out_s   = lk_entry_s[OUT_W-1:0];
    if (vld_q[lk_idx_s] && ({1'b0, lk_next_s} < NUM_STATES_L)) begin
      lk_hit_s = 1'b1;
    end else begin
      lk_hit_s = 1'b0;
    end
  end

  // Next valid-bit vector: a legal write marks its entry as programmed.
  always_comb begin
    vld_d = vld_q;
    if (wr_ok_s) begin
      vld_d[bus.wr_addr] = 1'b1;
    end else begin
      vld_d = vld_q;
    end
  end

  // Next state, output code, sticky error and saturating step count.
  always_comb begin
    state_d = state_q;
    saida_d = saida_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    if (err_q) begin
      // Steps are frozen while the error is pending; only clr_err acts.
      if (bus.clr_err) begin
        err_d = 1'b0;
      end else begin
        err_d = 1'b1;
      end
    end else if (bus.step) begin
      if (lk_hit_s) begin
        state_d = lk_next_s;
        saida_d = lk_out_s;
        if (cnt_q != CNT_MAX_L) begin
          cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
          cnt_d = cnt_q;
        end
      end else begin
        // A faulting step beats a simultaneous clr_err.
        err_d = 1'b1;
      end
    end else begin
      err_d = err_q;
    end
  end

  // Table payload registers; deliberately without reset.
  always_ff @(posedge clk) begin
    if (wr_ok_s) begin
      tbl_q[bus.wr_addr] <= bus.wr_data;
    end
  end

  // Valid bits, cleared asynchronously so reset invalidates the whole table.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_q <= '0;
    end else begin
      vld_q <= vld_d;
    end
  end

  // Machine registers with asynchronous reset to the configured start point.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= RST_STATE_L;
      saida_q <= RST_OUT_L;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      saida_q <= saida_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.state    = state_q;
  assign bus.saida    = saida_q;
  assign bus.err      = err_q;
  assign bus.step_cnt = cnt_q;

endmodule

// File: tb/tb_table_fsm.sv
// Self-checking bench for table_fsm: directed vector table, hand sequences
// for asynchronous reset and counter saturation, and a randomized run
// compared against a behavioural model of the transition table.
module tb_table_fsm;

  logic clk;
  logic rst0;
  logic rst1;
  int   checks;
  int   errors;

  table_fsm_if #(.STATE_W(3), .IN_W(1), .OUT_W(3), .CNT_W(8)) bus0 ();
  table_fsm_if #(.STATE_W(3), .IN_W(1), .OUT_W(3), .CNT_W(2)) bus1 ();

  table_fsm #(.STATE_W(3), .IN_W(1), .OUT_W(3), .NUM_STATES(6),
              .RESET_STATE(0), .RESET_OUT(0), .CNT_W(8)) dut0 (
    .clk(clk), .reset(rst0), .bus(bus0.slave));

  table_fsm #(.STATE_W(3), .IN_W(1), .OUT_W(3), .NUM_STATES(6),
              .RESET_STATE(0), .RESET_OUT(0), .CNT_W(2)) dut1 (
    .clk(clk), .reset(rst1), .bus(bus1.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       step;
    logic       a;
    logic       wr_en;
    logic [3:0] wr_addr;
    logic [5:0] wr_data;
    logic       clr;
    logic [2:0] st;
    logic [2:0] so;
    logic       er;
    logic [7:0] cnt;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic rst, input logic step, input logic a,
                              input logic wr_en, input logic [3:0] wr_addr,
                              input logic [5:0] wr_data, input logic clr,
                              input logic [2:0] st, input logic [2:0] so,
                              input logic er, input logic [7:0] cnt);
    vec_t v;
    v.rst = rst; v.step = step; v.a = a; v.wr_en = wr_en; v.wr_addr = wr_addr;
    v.wr_data = wr_data; v.clr = clr; v.st = st; v.so = so; v.er = er; v.cnt = cnt;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk0(input string tag, input int st, input int so, input int er, input int cnt);
    chk({tag, " state"}, 32'(bus0.state), st);
    chk({tag, " saida"}, 32'(bus0.saida), so);
    chk({tag, " err"},   32'(bus0.err), er);
    chk({tag, " cnt"},   32'(bus0.step_cnt), cnt);
  endtask

  task automatic chk1(input string tag, input int st, input int so, input int er, input int cnt);
    chk({tag, " state"}, 32'(bus1.state), st);
    chk({tag, " saida"}, 32'(bus1.saida), so);
    chk({tag, " err"},   32'(bus1.err), er);
    chk({tag, " cnt"},   32'(bus1.step_cnt), cnt);
  endtask

  task automatic idle0();
    bus0.step = 1'b0; bus0.a = 1'b0; bus0.wr_en = 1'b0;
    bus0.wr_addr = 4'd0; bus0.wr_data = 6'd0; bus0.clr_err = 1'b0;
  endtask

  task automatic idle1();
    bus1.step = 1'b0; bus1.a = 1'b0; bus1.wr_en = 1'b0;
    bus1.wr_addr = 4'd0; bus1.wr_data = 6'd0; bus1.clr_err = 1'b0;
  endtask

  task automatic cyc1(input logic step, input logic wr_en, input logic [3:0] addr,
                      input logic [5:0] data);
    bus1.step = step; bus1.a = 1'b0; bus1.wr_en = wr_en;
    bus1.wr_addr = addr; bus1.wr_data = data;
    @(posedge clk);
    #1;
    idle1();
  endtask

  // Behavioural model of the table and machine used by the random phase.
  int  m_next [16];
  int  m_out  [16];
  bit  m_vld  [16];
  int  m_state, m_saida, m_cnt;
  bit  m_err;

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_vld[i] = 1'b0;
    m_state = 0; m_saida = 0; m_err = 1'b0; m_cnt = 0;
  endtask

  initial begin
    int idx;
    bit s, av, w, c;
    int wa, wd;
    checks = 0;
    errors = 0;
    idle0();
    idle1();
    rst0 = 1'b1;
    rst1 = 1'b1;
    #3;
    rst0 = 1'b0;
    rst1 = 1'b0;
    chk0("por", 0, 0, 0, 0);

    // ---- directed vectors (reset, cyclic program, branches, faults, write/step overlap)
    vecs.push_back(mk(0,1,0,0,4'd0,6'd0,0,  0,0,1,0));   // all invalid -> err
    vecs.push_back(mk(1,0,0,0,4'd0,6'd0,0,  0,0,0,0));   // reset
    vecs.push_back(mk(0,0,0,1,4'd0,6'd11,0, 0,0,0,0));   // {0,0}->(1,3)
    vecs.push_back(mk(0,0,0,1,4'd2,6'd21,0, 0,0,0,0));   // {1,0}->(2,5)
    vecs.push_back(mk(0,0,0,1,4'd4,6'd2,0,  0,0,0,0));   // {2,0}->(0,2)
    vecs.push_back(mk(0,1,0,0,4'd0,6'd0,0,  1,3,0,1));
    vecs.push_back(mk(0,1,0,0,4'd0,6'd0,0,  2,5,0,2));
    vecs.push_back(mk(0,1,0,0,4'd0,6'd0,0,  0,2,0,3));
    vecs.push_back(mk(0,1,0,0,4'd0,6'd0,0,  1,3,0,4));
    vecs.push_back(mk(0,0,0,1,4'd3,6'd39,0, 1,3,0,4));   // {1,1}->(4,7)
    vecs.push_back(mk(0,0,0,1,4'd8,6'd6,0,  1,3,0,4));   // {4,0}->(0,6)
    vecs.push_back(mk(0,1,1,0,4'd0,6'd0,0,  4,7,0,5));
    vecs.push_back(mk(0,1,0,0,4'd0,6'd0,0,  0,6,0,6));
    vecs.push_back(mk(0,1,1,0,4'd0,6'd0,0,  0,6,1,6));   // {0,1} unprogrammed
    vecs.push_back(mk(0,1,1,0,4'd0,6'd0,0,  0,6,1,6));
    vecs.push_back(mk(0,1,0,0,4'd0,6'd0,0,  0,6,1,6));   // valid entry still blocked
    vecs.push_back(mk(0,0,0,0,4'd0,6'd0,1,  0,6,0,6));   // clr_err
    vecs.push_back(mk(0,0,0,1,4'd1,6'd57,0, 0,6,0,6));   // {0,1}->(7,1)
    vecs.push_back(mk(0,1,1,0,4'd0,6'd0,0,  0,6,1,6));   // 7 out of range
    vecs.push_back(mk(0,0,0,0,4'd0,6'd0,1,  0,6,0,6));
    vecs.push_back(mk(0,1,0,0,4'd0,6'd0,0,  1,3,0,7));
    vecs.push_back(mk(0,1,0,0,4'd0,6'd0,0,  2,5,0,8));
    vecs.push_back(mk(0,1,0,1,4'd4,6'd12,0, 0,2,0,9));   // old {2,0} used
    vecs.push_back(mk(0,1,0,0,4'd0,6'd0,0,  1,3,0,10));
    vecs.push_back(mk(0,1,0,0,4'd0,6'd0,0,  2,5,0,11));
    vecs.push_back(mk(0,1,0,0,4'd0,6'd0,0,  1,4,0,12));  // new {2,0}
    vecs.push_back(mk(0,1,1,0,4'd0,6'd0,0,  4,7,0,13));
    vecs.push_back(mk(0,1,1,0,4'd0,6'd0,1,  4,7,1,13));  // fault beats clr_err
    vecs.push_back(mk(0,0,0,0,4'd0,6'd0,1,  4,7,0,13));
    vecs.push_back(mk(0,1,1,1,4'd9,6'd5,0,  4,7,1,13));  // pre-write valid bit used
    vecs.push_back(mk(0,0,0,0,4'd0,6'd0,1,  4,7,0,13));
    vecs.push_back(mk(0,1,1,0,4'd0,6'd0,0,  0,5,0,14));  // written {4,1}->(0,5)
    vecs.push_back(mk(0,0,0,1,4'd13,6'd0,0, 0,5,0,14));  // row 6: ignored, no error

    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].rst) begin
        rst0 = 1'b1;
        #1;
        rst0 = 1'b0;
        #1;
      end else begin
        bus0.step = vecs[i].step; bus0.a = vecs[i].a; bus0.wr_en = vecs[i].wr_en;
        bus0.wr_addr = vecs[i].wr_addr; bus0.wr_data = vecs[i].wr_data;
        bus0.clr_err = vecs[i].clr;
        @(posedge clk);
        #1;
        idle0();
      end
      chk0($sformatf("vec%0d", i), int'(vecs[i].st), int'(vecs[i].so),
           int'(vecs[i].er), int'(vecs[i].cnt));
    end

    // ---- asynchronous reset between edges, then every entry must be invalid
    #2;
    rst0 = 1'b1;
    #1;
    chk0("async_rst", 0, 0, 0, 0);
    rst0 = 1'b0;
    bus0.step = 1'b1;
    @(posedge clk);
    #1;
    idle0();
    chk0("post_rst_step", 0, 0, 1, 0);

    // ---- saturating 2-bit counter with the cyclic table, reset mid-run
    cyc1(1'b0, 1'b1, 4'd0, 6'd11);
    cyc1(1'b0, 1'b1, 4'd2, 6'd21);
    cyc1(1'b0, 1'b1, 4'd4, 6'd2);
    cyc1(1'b1, 1'b0, 4'd0, 6'd0); chk1("sat1", 1, 3, 0, 1);
    cyc1(1'b1, 1'b0, 4'd0, 6'd0); chk1("sat2", 2, 5, 0, 2);
    cyc1(1'b1, 1'b0, 4'd0, 6'd0); chk1("sat3", 0, 2, 0, 3);
    cyc1(1'b1, 1'b0, 4'd0, 6'd0); chk1("sat4", 1, 3, 0, 3);
    cyc1(1'b1, 1'b0, 4'd0, 6'd0); chk1("sat5", 2, 5, 0, 3);
    bus1.step = 1'b1;
    #2;
    rst1 = 1'b1;
    #1;
    chk1("sat_rst", 0, 0, 0, 0);
    rst1 = 1'b0;
    @(posedge clk);
    #1;
    idle1();
    chk1("sat_rst_step", 0, 0, 1, 0);

    // ---- randomized run against the behavioural model
    rst0 = 1'b1;
    #1;
    rst0 = 1'b0;
    model_reset();
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 99) == 0) begin
        rst0 = 1'b1;
        #1;
        rst0 = 1'b0;
        model_reset();
      end
      s  = ($urandom_range(0, 9) < 6);
      av = 1'($urandom_range(0, 1));
      w  = ($urandom_range(0, 9) < 4);
      c  = ($urandom_range(0, 9) < 2);
      wa = $urandom_range(0, 15);
      wd = $urandom_range(0, 63);
      bus0.step = s; bus0.a = av; bus0.wr_en = w;
      bus0.wr_addr = 4'(wa); bus0.wr_data = 6'(wd); bus0.clr_err = c;
      // model: step decision uses table contents before this cycle's write
      idx = m_state * 2 + int'(av);
      if (m_err) begin
        if (c) m_err = 1'b0;
      end else if (s) begin
        if (m_vld[idx] && m_next[idx] < 6) begin
          m_state = m_next[idx];
          m_saida = m_out[idx];
          if (m_cnt < 255) m_cnt++;
        end else begin
          m_err = 1'b1;
        end
      end
      if (w && (wa / 2) < 6) begin
        m_vld[wa]  = 1'b1;
        m_next[wa] = wd / 8;
        m_out[wa]  = wd % 8;
      end
      @(posedge clk);
      #1;
      idle0();
      chk0($sformatf("rnd%0d", n), m_state, m_saida, int'(m_err), m_cnt);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
